// File: rtl/gate_bist_pkg.sv
// Shared types for the gate BIST sequencer.
// Build option: GATE_BIST_STOP_ON_FAIL_EN ends a sweep at the first mismatch.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_AND,
        OP_NAND,
        OP_OR,
        OP_XOR
    } gate_op_t;

    localparam int NUM_VECTORS = 4;

endpackage

// File: rtl/gate_ref_model.sv
// Expected output of the gate under test for a given function and input pair.
// Used by gate_bist_sequencer; see GATE_BIST_STOP_ON_FAIL_EN in the top.
module gate_ref_model
    import gate_bist_pkg::*;
(
    input  gate_op_t op,
    input  logic     a,
    input  logic     b,
    output logic     exp
);

    always_comb begin
        exp = 1'b0;
        unique case (op)
            OP_AND:  exp = a & b;
            OP_NAND: exp = ~(a & b);
            OP_OR:   exp = a | b;
            OP_XOR:  exp = a ^ b;
        endcase
    end

endmodule

// File: rtl/gate_bist_sequencer.sv
// Exhaustive truth-table sweep and response check for one 2-input gate.
// Define GATE_BIST_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_bist_sequencer
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_r,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    gate_op_t   op_q;
    logic [1:0] vec;
    logic [3:0] settle_cnt;
    logic       exp;
    logic       mismatch;
    logic       last;
    logic [2:0] err_next;

    gate_ref_model u_ref (
        .op  (op_q),
        .a   (dut_a),
        .b   (dut_b),
        .exp (exp)
    );

    // X on dut_r must count as a failure, hence the 4-state compare
    assign mismatch = (dut_r !== exp);
    assign err_next = err_count + {2'b00, mismatch};

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    assign last = (vec == LAST_VEC) || mismatch;
`else
    assign last = (vec == LAST_VEC);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= OP_AND;
            vec        <= 2'd0;
            settle_cnt <= 4'd0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_vec   <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= gate_op_t'(op);
                        vec       <= 2'd0;
                        err_count <= 3'd0;
                        fail_vec  <= 4'd0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    {dut_a, dut_b} <= vec;
                    settle_cnt     <= SETTLE_LOAD;
                    state          <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    fail_vec  <= fail_vec | (4'(mismatch) << vec);
                    if (last) begin
                        done  <= 1'b1;
                        pass  <= (err_next == 3'd0);
                        state <= DONE;
                    end else begin
                        vec   <= vec + 2'd1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
